// File: rtl/figan_pkg.sv
// ---------------------------------------------------------------------------
// figan_pkg
// Shared definitions for the FI-GAN generator convolution layers.
//   FRAC_BITS     default number of fractional bits (Q5.10 at 16-bit width)
//   ACT_*         output activation encodings
//   acc_width()   accumulator width for a 9-tap MAC at a given sample width
//   mac_state_e   FSM state encoding shared by the MAC engines
// ---------------------------------------------------------------------------
package figan_pkg;

    localparam int FRAC_BITS = 10;

    localparam int ACT_NONE  = 0;
    localparam int ACT_RELU  = 1;
    localparam int ACT_HTANH = 2;

    // Each product is 2*dw bits. Four guard bits hold the 9-term sum plus the
    // shifted bias without wrapping.
    function automatic int acc_width(input int dw);
        return 2 * dw + 4;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_FIN  = 2'd2,
        ST_OUT  = 2'd3
    } mac_state_e;

endpackage

// File: rtl/fxp_round_sat.sv
// ---------------------------------------------------------------------------
// fxp_round_sat
// Combinational post-processing for a convolution accumulator:
//   res = act( sat( (acc + (bias <<< FRAC_BITS) + half_lsb) >>> FRAC_BITS ) )
// Rounding is half-up (toward +inf on exact halves), saturation is to the
// signed DATA_WIDTH range, activation is selected by ACT.
// Ports:
//   acc   in   ACC_WIDTH   signed accumulator, Q(2*FRAC_BITS)
//   bias  in   DATA_WIDTH  signed bias, Q(FRAC_BITS)
//   res   out  DATA_WIDTH  signed result, Q(FRAC_BITS)
// ---------------------------------------------------------------------------
module fxp_round_sat #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 10,
    parameter int ACC_WIDTH  = 36,
    parameter int ACT        = 2
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [DATA_WIDTH-1:0] res
);
    import figan_pkg::*;

    // One extra bit so the bias and rounding additions can never wrap.
    localparam int SW = ACC_WIDTH + 1;

    localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC_BITS - 1);
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] ONE_P = DATA_WIDTH'(1) << FRAC_BITS;
    localparam logic signed [DATA_WIDTH-1:0] ONE_N = -ONE_P;

    logic signed [SW-1:0]         acc_ext;
    logic signed [SW-1:0]         bias_ext;
    logic signed [SW-1:0]         sum;
    logic signed [SW-1:0]         shifted;
    logic signed [DATA_WIDTH-1:0] sat;

    assign acc_ext  = {{(SW - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    // Bias is Q(FRAC); align it to the Q(2*FRAC) accumulator.
    assign bias_ext = {{(SW - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} <<< FRAC_BITS;
    assign sum      = acc_ext + bias_ext + RND;
    assign shifted  = sum >>> FRAC_BITS;

    always_comb begin
        sat = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        res = sat;
        case (ACT)
            ACT_NONE: res = sat;
            ACT_RELU: res = sat[DATA_WIDTH-1] ? '0 : sat;
            ACT_HTANH: begin
                if (sat > ONE_P) begin
                    res = ONE_P;
                end else if (sat < ONE_N) begin
                    res = ONE_N;
                end
            end
            default: res = sat;
        endcase
    end

endmodule

// File: rtl/conv3x3_out_mac.sv
// ---------------------------------------------------------------------------
// conv3x3_out_mac
// Output-layer 3x3 convolution engine. Accepts one 3x3 window, serially
// multiply-accumulates the nine taps against the static weight set (one
// multiplier, 9 cycles), then adds bias, rounds, saturates and applies the
// activation, and presents one pixel on a valid/ready stream.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised the source holds it and its data until the
// transfer. in_ready is high only in IDLE and out_valid only in OUT, so an
// input is never accepted while a result is pending.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   w0..w8, bias         signed kernel taps and bias, held constant
//   win                  nine taps, tap k at win[k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid / in_ready  window stream
//   pix_out              result pixel, Q(FRAC_BITS)
//   out_valid/out_ready  pixel stream
//   dbg_state            current FSM state (mac_state_e encoding)
//
// Timing: accept edge -> 9 MAC edges -> FIN edge; out_valid rises on the 10th
// edge after the accept edge.
// ---------------------------------------------------------------------------
module conv3x3_out_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = figan_pkg::FRAC_BITS,
    parameter int ACT        = figan_pkg::ACT_HTANH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   w0,
    input  logic [DATA_WIDTH-1:0]   w1,
    input  logic [DATA_WIDTH-1:0]   w2,
    input  logic [DATA_WIDTH-1:0]   w3,
    input  logic [DATA_WIDTH-1:0]   w4,
    input  logic [DATA_WIDTH-1:0]   w5,
    input  logic [DATA_WIDTH-1:0]   w6,
    input  logic [DATA_WIDTH-1:0]   w7,
    input  logic [DATA_WIDTH-1:0]   w8,
    input  logic [DATA_WIDTH-1:0]   bias,
    input  logic [9*DATA_WIDTH-1:0] win,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   pix_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              dbg_state
);
    import figan_pkg::*;

    localparam int AW = acc_width(DATA_WIDTH);
    localparam int PW = 2 * DATA_WIDTH;

    mac_state_e state_q, state_d;

    logic [3:0]                tap_q;
    logic [9*DATA_WIDTH-1:0]   win_q;
    logic signed [AW-1:0]      acc_q;
    logic [DATA_WIDTH-1:0]     pix_q;

    logic signed [DATA_WIDTH-1:0] x_sel;
    logic signed [DATA_WIDTH-1:0] w_sel;
    logic signed [PW-1:0]         prod;
    logic signed [DATA_WIDTH-1:0] res;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (tap_q == 4'd8) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dbg_state = state_q;

    // ---------------- tap / weight mux ----------------
    always_comb begin
        x_sel = '0;
        w_sel = '0;
        case (tap_q)
            4'd0: begin x_sel = win_q[0*DATA_WIDTH +: DATA_WIDTH]; w_sel = w0; end
            4'd1: begin x_sel = win_q[1*DATA_WIDTH +: DATA_WIDTH]; w_sel = w1; end
            4'd2: begin x_sel = win_q[2*DATA_WIDTH +: DATA_WIDTH]; w_sel = w2; end
            4'd3: begin x_sel = win_q[3*DATA_WIDTH +: DATA_WIDTH]; w_sel = w3; end
            4'd4: begin x_sel = win_q[4*DATA_WIDTH +: DATA_WIDTH]; w_sel = w4; end
            4'd5: begin x_sel = win_q[5*DATA_WIDTH +: DATA_WIDTH]; w_sel = w5; end
            4'd6: begin x_sel = win_q[6*DATA_WIDTH +: DATA_WIDTH]; w_sel = w6; end
            4'd7: begin x_sel = win_q[7*DATA_WIDTH +: DATA_WIDTH]; w_sel = w7; end
            4'd8: begin x_sel = win_q[8*DATA_WIDTH +: DATA_WIDTH]; w_sel = w8; end
            default: begin x_sel = '0; w_sel = '0; end
        endcase
    end

    assign prod = x_sel * w_sel;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q <= '0;
            win_q <= '0;
            acc_q <= '0;
            pix_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        win_q <= win;
                        acc_q <= '0;
                        tap_q <= '0;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + {{(AW - PW){prod[PW-1]}}, prod};
                    tap_q <= tap_q + 4'd1;
                end
                ST_FIN: begin
                    pix_q <= res;
                end
                default: ;
            endcase
        end
    end

    fxp_round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (AW),
        .ACT        (ACT)
    ) u_round_sat (
        .acc  (acc_q),
        .bias (bias),
        .res  (res)
    );

    assign pix_out = pix_q;

endmodule
